// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared definitions for the reg_bank register block: bus op encoding,
// register index map, CTRL/STATUS bit positions and the default ID value.
// No ports.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } reg_op_e;

    // Register indices (word index, not byte address)
    localparam int unsigned ADDR_ID       = 32'h00;
    localparam int unsigned ADDR_CTRL     = 32'h01;
    localparam int unsigned ADDR_STATUS   = 32'h02;
    localparam int unsigned ADDR_COUNT    = 32'h03;
    localparam int unsigned ADDR_SCRATCH0 = 32'h10;

    // CTRL bit positions
    localparam int CTRL_CNT_EN_BIT  = 0;
    localparam int CTRL_CNT_CLR_BIT = 1;

    // STATUS bit positions
    localparam int STATUS_ERR_BIT    = 0;
    localparam int STATUS_CNT_EN_BIT = 1;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'hDE57_0001;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_counter.sv
// reg_bank_counter
// Free-running cycle counter for reg_bank: increments while enabled,
// synchronous clear that takes priority over increment, silent wrap.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active-low
//   en    - count enable
//   clr   - synchronous clear (wins over en)
//   count - current counter value
module reg_bank_counter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [DATA_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + DATA_W'(1);
        end
    end

endmodule : reg_bank_counter

// File: rtl/reg_bank.sv
// reg_bank
// Memory-mapped register bank behind a single-cycle op-coded register bus.
// Registers: ID (RO), CTRL, STATUS (sticky W1C ERR + CNT_EN mirror),
// COUNT (RO cycle counter) and NUM_SCRATCH full-width scratch registers
// starting at index 0x10.
// Build option: define REG_BANK_COUNTER_EN to generate the cycle counter and
// the CTRL CNT_EN/CNT_CLR bits; without it COUNT reads 0 and CTRL reads 0.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous reset, active-low
//   reg_op    - 00 NOP, 01 READ, 10 WRITE, 11 reserved (sets ERR)
//   reg_addr  - register index
//   reg_wdata - write data
//   reg_rdata - registered read data, updated only by READ
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 8,
    parameter int                NUM_SCRATCH = 4,
    parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(DEFAULT_ID_VALUE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        reg_op,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata
);

    localparam int IDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(ADDR_ID);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(ADDR_CTRL);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(ADDR_STATUS);
    localparam logic [ADDR_W-1:0] A_COUNT   = ADDR_W'(ADDR_COUNT);
    localparam logic [ADDR_W-1:0] A_SCR0    = ADDR_W'(ADDR_SCRATCH0);
    // One bit wider so the end bound cannot wrap for large NUM_SCRATCH
    localparam logic [ADDR_W:0]   A_SCR_END = (ADDR_W+1)'(ADDR_SCRATCH0 + NUM_SCRATCH);

    reg_op_e           op_p0;
    logic              is_read_p0;
    logic              is_write_p0;
    logic              in_scratch_p0;
    logic [ADDR_W-1:0] scr_off_p0;
    logic [IDX_W-1:0]  scr_idx_p0;
    logic              mapped_p0;
    logic [DATA_W-1:0] rd_val_p0;
    logic              wr_status_p0;
    logic              wr_scratch_p0;
    logic              err_set_p0;
    logic              err_clr_p0;

    logic              err;
    logic [DATA_W-1:0] scratch [NUM_SCRATCH];
    logic              cnt_en;
    logic [DATA_W-1:0] count;

    // ---- stage p0: decode of the op presented this cycle ----
    assign op_p0       = reg_op_e'(reg_op);
    assign is_read_p0  = (op_p0 == OP_READ);
    assign is_write_p0 = (op_p0 == OP_WRITE);

    assign scr_off_p0    = reg_addr - A_SCR0;
    assign scr_idx_p0    = scr_off_p0[IDX_W-1:0];
    assign in_scratch_p0 = (reg_addr >= A_SCR0) && ({1'b0, reg_addr} < A_SCR_END);

    // Read mux doubles as the address-map decoder: mapped_p0 drops for any
    // index that has no register behind it.
    always_comb begin
        rd_val_p0 = '0;
        mapped_p0 = 1'b1;
        case (reg_addr)
            A_ID:     rd_val_p0 = ID_VALUE;
            A_CTRL:   rd_val_p0[CTRL_CNT_EN_BIT] = cnt_en;
            A_STATUS: begin
                rd_val_p0[STATUS_ERR_BIT]    = err;
                rd_val_p0[STATUS_CNT_EN_BIT] = cnt_en;
            end
            A_COUNT:  rd_val_p0 = count;
            default: begin
                if (in_scratch_p0) begin
                    rd_val_p0 = scratch[scr_idx_p0];
                end else begin
                    mapped_p0 = 1'b0;
                end
            end
        endcase
    end

    assign wr_status_p0  = is_write_p0 && (reg_addr == A_STATUS);
    assign wr_scratch_p0 = is_write_p0 && in_scratch_p0;

    assign err_set_p0 = (op_p0 == OP_RSVD) || ((is_read_p0 || is_write_p0) && !mapped_p0);
    assign err_clr_p0 = wr_status_p0 && reg_wdata[STATUS_ERR_BIT];

    // ---- stage p1: registered state and read data ----
    // A new error beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= err_set_p0 | (err & ~err_clr_p0);
        end
    end

    // Read data holds across NOP/WRITE; unmapped reads return rd_val_p0 = 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_rdata <= '0;
        end else if (is_read_p0) begin
            reg_rdata <= rd_val_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else if (wr_scratch_p0) begin
            scratch[scr_idx_p0] <= reg_wdata;
        end
    end

`ifdef REG_BANK_COUNTER_EN
    logic wr_ctrl_p0;
    logic cnt_clr_p0;

    assign wr_ctrl_p0 = is_write_p0 && (reg_addr == A_CTRL);
    // CNT_CLR is a pulse derived from the write itself; it is never stored,
    // so CTRL bit1 always reads 0.
    assign cnt_clr_p0 = wr_ctrl_p0 && reg_wdata[CTRL_CNT_CLR_BIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_en <= 1'b0;
        end else if (wr_ctrl_p0) begin
            cnt_en <= reg_wdata[CTRL_CNT_EN_BIT];
        end
    end

    reg_bank_counter #(
        .DATA_W (DATA_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .clr   (cnt_clr_p0),
        .count (count)
    );
`else
    // No counter: COUNT and the CTRL/STATUS enable bits are tied off.
    assign cnt_en = 1'b0;
    assign count  = '0;
`endif

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// tb_reg_bank
// Self-checking bench for reg_bank: directed register sequences with
// literal expectations, then randomized ops checked every cycle against
// a behavioural register-map model. Follows REG_BANK_COUNTER_EN.
module tb_reg_bank;

    localparam int NS = 4;
    localparam logic [31:0] ID = 32'hDE57_0001;

    logic        clk;
    logic        rst;
    logic [1:0]  reg_op;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    reg_bank #(
        .DATA_W      (32),
        .ADDR_W      (8),
        .NUM_SCRATCH (NS),
        .ID_VALUE    (ID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_op    (reg_op),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 0;

    // Behavioural model state
    logic [31:0] m_scr [NS];
    bit          m_err;
    bit          m_en;
    logic [31:0] m_cnt;
    logic [31:0] m_rd;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) m_scr[i] = '0;
        m_err = 0;
        m_en  = 0;
        m_cnt = '0;
        m_rd  = '0;
    endfunction

    function automatic bit is_mapped(int a);
        return (a <= 3) || (a >= 16 && a < 16 + NS);
    endfunction

    function automatic logic [31:0] model_read(int a);
        if (a == 0) return ID;
        if (a == 1) return {31'd0, m_en};
        if (a == 2) return {30'd0, m_en, m_err};
        if (a == 3) return m_cnt;
        return m_scr[a - 16];
    endfunction

    // One bus cycle of the register map, as seen from outside.
    function automatic void model_step(logic [1:0] op, logic [7:0] addr, logic [31:0] wd);
        int          a       = int'(addr);
        bit          set_err = 0;
        bit          clr_cnt = 0;
        bit          en_old  = m_en;
        case (op)
            2'b01: begin
                if (is_mapped(a)) m_rd = model_read(a);
                else begin m_rd = '0; set_err = 1; end
            end
            2'b10: begin
                if (!is_mapped(a)) set_err = 1;
                else begin
`ifdef REG_BANK_COUNTER_EN
                    if (a == 1) begin
                        m_en    = wd[0];
                        clr_cnt = wd[1];
                    end
`endif
                    if (a == 2 && wd[0]) m_err = 0;
                    if (a >= 16) m_scr[a - 16] = wd;
                end
            end
            2'b11: set_err = 1;
            default: ;
        endcase
        if (set_err) m_err = 1;
`ifdef REG_BANK_COUNTER_EN
        if (clr_cnt) m_cnt = '0;
        else if (en_old) m_cnt = m_cnt + 1;
`else
        m_cnt = '0;
        if (clr_cnt || en_old) m_cnt = '0;
`endif
    endfunction

    task automatic do_op(logic [1:0] op, logic [7:0] addr, logic [31:0] wd);
        @(negedge clk);
        reg_op    = op;
        reg_addr  = addr;
        reg_wdata = wd;
        @(posedge clk);
        model_step(op, addr, wd);
    endtask

    task automatic rd_chk(string name, logic [7:0] addr, logic [31:0] exp);
        do_op(2'b01, addr, 32'd0);
        #1;
        chk(name, reg_rdata, exp);
    endtask

    // Every-cycle comparison of the only output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!done) chk("rdata_cycle", reg_rdata, m_rd);
        end
    end

    initial begin
        logic [7:0]  addr;
        logic [1:0]  op;
        int          r;
        model_reset();
        rst       = 1'b0;
        reg_op    = 2'b00;
        reg_addr  = '0;
        reg_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", reg_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset values
        rd_chk("id", 8'h00, 32'hDE57_0001);
        rd_chk("ctrl_reset", 8'h01, 32'd0);
        rd_chk("status_reset", 8'h02, 32'd0);
        rd_chk("scr0_reset", 8'h10, 32'd0);

        // Scratch write/read, neighbours untouched
        do_op(2'b10, 8'h11, 32'hA5A5_5A5A);
        rd_chk("scr1_rw", 8'h11, 32'hA5A5_5A5A);
        rd_chk("scr0_untouched", 8'h10, 32'd0);

        // NOP and WRITE hold read data
        rd_chk("scr1_again", 8'h11, 32'hA5A5_5A5A);
        do_op(2'b00, 8'h00, 32'd0);
        do_op(2'b10, 8'h13, 32'h1234_5678);
        #1;
        chk("rdata_hold", reg_rdata, 32'hA5A5_5A5A);

        // Unmapped read, sticky ERR, W1C, RO write
        rd_chk("unmapped_rd", 8'h40, 32'd0);
        rd_chk("err_set", 8'h02, 32'd1);
        do_op(2'b10, 8'h02, 32'd1);
        rd_chk("err_w1c", 8'h02, 32'd0);
        do_op(2'b10, 8'h00, 32'd0);
        rd_chk("id_ro", 8'h00, 32'hDE57_0001);
        rd_chk("err_ro_wr", 8'h02, 32'd0);

        // Reserved op and unmapped write both set ERR
        do_op(2'b11, 8'h10, 32'hFFFF_FFFF);
        rd_chk("err_rsvd", 8'h02, 32'd1);
        rd_chk("rsvd_no_wr", 8'h10, 32'd0);
        do_op(2'b10, 8'h02, 32'd1);
        do_op(2'b10, 8'h14, 32'hDEAD_BEEF);
        rd_chk("err_unmapped_wr", 8'h02, 32'd1);
        do_op(2'b10, 8'h02, 32'd1);

`ifdef REG_BANK_COUNTER_EN
        do_op(2'b10, 8'h01, 32'd1);
        repeat (10) do_op(2'b00, 8'h00, 32'd0);
        rd_chk("count_10", 8'h03, 32'd10);
        do_op(2'b10, 8'h01, 32'd3);
        rd_chk("count_clr", 8'h03, 32'd0);
        rd_chk("ctrl_rb", 8'h01, 32'd1);
        rd_chk("status_en", 8'h02, 32'd2);
        do_op(2'b10, 8'h01, 32'd0);
`else
        do_op(2'b10, 8'h01, 32'd1);
        rd_chk("count_off", 8'h03, 32'd0);
        rd_chk("ctrl_off", 8'h01, 32'd0);
        rd_chk("status_off", 8'h02, 32'd0);
`endif

        // Reset mid-WRITE to 0x12, with non-zero read data beforehand
        rd_chk("id_pre_rst", 8'h00, 32'hDE57_0001);
        @(negedge clk);
        reg_op    = 2'b10;
        reg_addr  = 8'h12;
        reg_wdata = 32'hCAFE_F00D;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rdata_in_rst", reg_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reg_op = 2'b00;
        rst    = 1'b1;
        #1;
        chk("rdata_after_rst", reg_rdata, 32'd0);
        rd_chk("scr2_after_rst", 8'h12, 32'd0);
        rd_chk("scr1_after_rst", 8'h11, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      op = 2'b00;
            else if (r < 6) op = 2'b01;
            else if (r < 9) op = 2'b10;
            else            op = 2'b11;
            r = int'($urandom_range(0, 9));
            if (r < 4)      addr = 8'($urandom_range(0, 3));
            else if (r < 8) addr = 8'(16 + $urandom_range(0, NS - 1));
            else            addr = 8'($urandom_range(0, 255));
            do_op(op, addr, $urandom);
        end

        @(negedge clk);
        done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reg_bank
